// File: rtl/trivium_stream.sv
// Trivium keystream generator: W rounds unrolled per clock, key/IV init handshake,
// warm-up sequencing and a one-deep valid/ready output register.

module trivium_round (
  input  logic [92:0]  a,
  input  logic [83:0]  b,
  input  logic [110:0] c,
  output logic [92:0]  a_nx,
  output logic [83:0]  b_nx,
  output logic [110:0] c_nx,
  output logic         z
);
  logic t1, t2, t3;

  // a[i] = s(i+1), b[j] = s(j+94), c[k] = s(k+178) in the usual s1..s288 numbering
  assign t1 = a[65] ^ a[92];
  assign t2 = b[68] ^ b[83];
  assign t3 = c[65] ^ c[110];
  assign z  = t1 ^ t2 ^ t3;

  assign a_nx = {a[91:0],  t3 ^ (c[108] & c[109]) ^ a[68]};
  assign b_nx = {b[82:0],  t1 ^ (a[90]  & a[91])  ^ b[77]};
  assign c_nx = {c[109:0], t2 ^ (b[81]  & b[82])  ^ c[86]};
endmodule

module trivium_stream #(
  parameter int W             = 1,
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_valid,
  output logic         init_ready,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ks,
  output logic         warm_up_complete,
  output logic         busy
);
  localparam int N  = WARMUP_ROUNDS / W;
  localparam int CW = $clog2(N + 1);

  localparam bit W_OK = (W == 1) || (W == 2) || (W == 4) || (W == 8) ||
                        (W == 16) || (W == 32) || (W == 64);
  if (!W_OK) begin : g_bad_w
    $error("trivium_stream: W must be one of 1,2,4,8,16,32,64");
  end
  if ((WARMUP_ROUNDS % W) != 0 || WARMUP_ROUNDS < W) begin : g_bad_warmup
    $error("trivium_stream: WARMUP_ROUNDS must be a positive multiple of W");
  end

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  state_t fsm, fsm_nx;

  logic [92:0]  a_q;
  logic [83:0]  b_q;
  logic [110:0] c_q;
  logic [CW-1:0] cnt;
  logic [W-1:0] z_w;
  logic load, adv, emit, clr_vld;

  // Unrolled round chain; each stage feeds the next within the same cycle.
  for (genvar i = 0; i < W; i++) begin : g_rnd
    logic [92:0]  a_i, a_o;
    logic [83:0]  b_i, b_o;
    logic [110:0] c_i, c_o;
    if (i == 0) begin : g_head
      assign a_i = a_q;
      assign b_i = b_q;
      assign c_i = c_q;
    end else begin : g_link
      assign a_i = g_rnd[i-1].a_o;
      assign b_i = g_rnd[i-1].b_o;
      assign c_i = g_rnd[i-1].c_o;
    end
    trivium_round u_rnd (
      .a(a_i), .b(b_i), .c(c_i),
      .a_nx(a_o), .b_nx(b_o), .c_nx(c_o),
      .z(z_w[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nx;
  end

  always_comb begin
    fsm_nx  = fsm;
    load    = 1'b0;
    adv     = 1'b0;
    emit    = 1'b0;
    clr_vld = 1'b0;
    unique case (fsm)
      IDLE: if (init_valid) begin
        load   = 1'b1;
        fsm_nx = WARMUP;
      end
      WARMUP: begin
        adv = 1'b1;
        if (cnt == CW'(N - 1)) fsm_nx = RUN;
      end
      RUN: begin
        // Re-key wins over a new emit; a word handshaken this cycle is already delivered.
        if (init_valid) begin
          load    = 1'b1;
          clr_vld = 1'b1;
          fsm_nx  = WARMUP;
        end else if (!out_valid || out_ready) begin
          emit = 1'b1;
          adv  = 1'b1;
        end
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      cnt       <= '0;
      ks        <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        a_q <= {13'b0, key};
        b_q <= {4'b0, iv};
        c_q <= {3'b111, 108'b0};
      end else if (adv) begin
        a_q <= g_rnd[W-1].a_o;
        b_q <= g_rnd[W-1].b_o;
        c_q <= g_rnd[W-1].c_o;
      end
      if (load)              cnt <= '0;
      else if (fsm == WARMUP) cnt <= cnt + 1'b1;
      if (clr_vld) out_valid <= 1'b0;
      else if (emit) begin
        out_valid <= 1'b1;
        ks        <= z_w;
      end
    end
  end

  assign init_ready       = (fsm != WARMUP);
  assign warm_up_complete = (fsm == RUN);
  assign busy             = (fsm == WARMUP);
endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: W=1/8/64 instances checked against a bit-serial
// reference through an expected-word queue, plus re-key, warm-up and reset cases.

module tb_trivium_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [79:0] key, iv;
  logic [2:0]  init_v, out_r, irdy, ov, wuc, bsy;
  logic [0:0]  ks1;
  logic [7:0]  ks8;
  logic [63:0] ks64;

  trivium_stream #(.W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .init_valid(init_v[0]), .init_ready(irdy[0]),
    .key(key), .iv(iv), .out_valid(ov[0]), .out_ready(out_r[0]), .ks(ks1),
    .warm_up_complete(wuc[0]), .busy(bsy[0]));
  trivium_stream #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .init_valid(init_v[1]), .init_ready(irdy[1]),
    .key(key), .iv(iv), .out_valid(ov[1]), .out_ready(out_r[1]), .ks(ks8),
    .warm_up_complete(wuc[1]), .busy(bsy[1]));
  trivium_stream #(.W(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .init_valid(init_v[2]), .init_ready(irdy[2]),
    .key(key), .iv(iv), .out_valid(ov[2]), .out_ready(out_r[2]), .ks(ks64),
    .warm_up_complete(wuc[2]), .busy(bsy[2]));

  logic [1:0]  sel;
  logic [63:0] ks_s;
  logic        ov_s, irdy_s, wuc_s, bsy_s;

  always_comb begin
    ks_s   = ks64;
    ov_s   = ov[2];
    irdy_s = irdy[2];
    wuc_s  = wuc[2];
    bsy_s  = bsy[2];
    case (sel)
      2'd0: begin
        ks_s = {63'b0, ks1}; ov_s = ov[0]; irdy_s = irdy[0]; wuc_s = wuc[0]; bsy_s = bsy[0];
      end
      2'd1: begin
        ks_s = {56'b0, ks8}; ov_s = ov[1]; irdy_s = irdy[1]; wuc_s = wuc[1]; bsy_s = bsy[1];
      end
      default: ;
    endcase
  end

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [63:0]  exp_q[$];
  logic [287:0] ms;  // ms[k-1] holds s_k

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    ms = '0;
    ms[79:0]    = k;
    ms[172:93]  = v;
    ms[287:285] = 3'b111;
  endtask

  task automatic model_step(output logic z);
    logic t1, t2, t3;
    t1 = ms[66-1]  ^ ms[93-1];
    t2 = ms[162-1] ^ ms[177-1];
    t3 = ms[243-1] ^ ms[288-1];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91-1]  & ms[92-1])  ^ ms[171-1];
    t2 = t2 ^ (ms[175-1] & ms[176-1]) ^ ms[264-1];
    t3 = t3 ^ (ms[286-1] & ms[287-1]) ^ ms[69-1];
    ms = {ms[286:177], t2, ms[175:93], t1, ms[91:0], t3};
  endtask

  task automatic push_words(input logic [79:0] k, input logic [79:0] v, input int w, input int n);
    logic z;
    logic [63:0] word;
    model_load(k, v);
    repeat (1152) model_step(z);
    for (int j = 0; j < n; j++) begin
      word = '0;
      for (int i = 0; i < w; i++) begin
        model_step(z);
        word[i] = z;
      end
      exp_q.push_back(word);
    end
  endtask

  // Called on a negedge: handshake at the next posedge, then measure warm-up.
  task automatic do_init(input int expn, input int pulse_at);
    int n, nb;
    check("init_ready_idle", 64'(irdy_s), 64'd1);
    init_v[sel] = 1'b1;
    @(negedge clk);
    init_v[sel] = 1'b0;
    check("valid_after_accept", 64'(ov_s), 64'd0);
    check("init_ready_warmup", 64'(irdy_s), 64'd0);
    nb = int'(bsy_s);
    n  = 0;
    while (n < expn + 50) begin
      if (n == pulse_at) begin
        check("init_ready_on_pulse", 64'(irdy_s), 64'd0);
        init_v[sel] = 1'b1;
        key = {16'($urandom()), $urandom(), $urandom()};
      end else begin
        init_v[sel] = 1'b0;
      end
      @(negedge clk);
      n++;
      if (ov_s) break;
      nb += int'(bsy_s);
    end
    init_v[sel] = 1'b0;
    check("first_valid_latency", 64'(n), 64'(expn));
    check("busy_cycles", 64'(nb), 64'(expn - 1));
    check("warm_up_complete", 64'(wuc_s), 64'd1);
  endtask

  task automatic run_stream(input int n, input bit rnd);
    int got, cyc;
    bit pstall;
    logic [63:0] pks, e;
    got = 0; cyc = 0; pstall = 1'b0; pks = '0;
    while (got < n && cyc < n * 8 + 100) begin
      out_r[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pstall) begin
        check("stall_valid", 64'(ov_s), 64'd1);
        check("stall_ks", ks_s, pks);
      end
      pstall = ov_s && !out_r[sel];
      pks    = ks_s;
      if (ov_s && out_r[sel]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check("ks_word", ks_s, e);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_words", 64'(got), 64'(n));
  endtask

  initial begin
    logic [63:0] e;
    int hits;
    sel = 2'd0; init_v = '0; out_r = '0; key = '0; iv = '0;
    repeat (3) @(negedge clk);

    check("rst_out_valid", 64'(ov_s), 64'd0);
    check("rst_ks", ks_s, 64'd0);
    check("rst_ks_w64", ks64, 64'd0);
    check("rst_wuc", 64'(wuc_s), 64'd0);
    check("rst_busy", 64'(bsy_s), 64'd0);
    check("rst_init_ready", 64'(irdy_s), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // W=1 baseline stream
    key = {16'($urandom()), $urandom(), $urandom()};
    iv  = {16'($urandom()), $urandom(), $urandom()};
    push_words(key, iv, 1, 4096);
    out_r[0] = 1'b1;
    do_init(1153, -1);
    run_stream(4096, 1'b0);

    // W=8, same key/IV, LSB-first packing
    sel = 2'd1;
    exp_q.delete();
    push_words(key, iv, 8, 512);
    out_r[1] = 1'b1;
    do_init(145, -1);
    run_stream(512, 1'b0);

    // W=64 with random backpressure; one spare word for the re-key step
    sel = 2'd2;
    exp_q.delete();
    push_words(key, iv, 64, 65);
    do_init(19, -1);
    run_stream(64, 1'b1);

    // Re-key while the pending word is handshaken in the same cycle
    check("rekey_pending_valid", 64'(ov_s), 64'd1);
    out_r[2] = 1'b1;
    e = exp_q.pop_front();
    check("rekey_delivered_word", ks_s, e);
    key = {16'($urandom()), $urandom(), $urandom()};
    iv  = {16'($urandom()), $urandom(), $urandom()};
    exp_q.delete();
    push_words(key, iv, 64, 16);
    do_init(19, -1);
    run_stream(16, 1'b0);

    // init_valid pulsed mid warm-up must be ignored
    sel = 2'd1;
    key = {16'($urandom()), $urandom(), $urandom()};
    exp_q.delete();
    push_words(key, iv, 8, 32);
    do_init(145, 50);
    run_stream(32, 1'b0);

    // Asynchronous reset mid-RUN with a word pending
    sel = 2'd2;
    check("pre_reset_valid", 64'(ov_s), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov_s), 64'd0);
    check("async_rst_ks", ks_s, 64'd0);
    check("async_rst_busy", 64'(bsy_s), 64'd0);
    check("async_rst_wuc", 64'(wuc_s), 64'd0);
    check("async_rst_init_ready", 64'(irdy_s), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      hits += int'(ov_s);
    end
    check("no_valid_after_reset", 64'(hits), 64'd0);
    key = {16'($urandom()), $urandom(), $urandom()};
    exp_q.delete();
    push_words(key, iv, 64, 8);
    do_init(19, -1);
    run_stream(8, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trivium_stream.md
# trivium_stream

Parametrised Trivium keystream generator. It produces `W` keystream bits per clock behind a valid/ready output handshake and supports re-keying through an init handshake. It replaces the single-bit, free-running generator in the stream-cipher datapath and feeds the XOR/encrypt stage. For `W=1` its output is bit-identical to the single-bit generator for the same key/IV.

## Interface

Parameters:
- `W`, default 1: keystream bits per output word. Legal values are 1, 2, 4, 8, 16, 32, 64. Any other value fails elaboration.
- `WARMUP_ROUNDS`, default 1152: initialisation rounds. Must be a multiple of `W`. Any other value fails elaboration.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `init_valid` input 1: a new key/IV is presented.
- `init_ready` output 1: the block can accept a key/IV.
- `key` input 80: key; sampled on the init handshake only.
- `iv` input 80: IV; sampled on the init handshake only.
- `out_valid` output 1: `ks` holds a valid keystream word.
- `out_ready` input 1: the consumer accepts `ks`.
- `ks` output `W`: keystream word. `ks[0]` is the earliest-generated bit.
- `warm_up_complete` output 1: high in RUN state.
- `busy` output 1: high in WARMUP state.

## Operation

- The 288-bit state is three registers.
  - A, 93 bits: `{13'b0, key}`.
  - B, 84 bits: `{4'b0, iv}`.
  - C, 111 bits: `{3'b111, 108'b0}`.
- Taps and update functions are identical to the existing single-bit generator.
- The round function is unrolled `W` times combinationally. One cycle advances the state by exactly `W` rounds.
  - Output bit i of the unrolled chain maps to `ks[i]`.
  - `W<=64` guarantees no intra-word tap dependency beyond the unroll chain.
- State machine:
  - IDLE (reset state):
    - `init_ready=1`, `out_valid=0`.
    - On `init_valid`, load the state from `key`/`iv` and go to WARMUP.
  - WARMUP:
    - `init_ready=0`, `busy=1`.
    - Advance `W` rounds per cycle and discard the output bits.
    - A cycle counter of width `$clog2(WARMUP_ROUNDS/W + 1)` counts `WARMUP_ROUNDS/W` cycles, then the FSM goes to RUN.
    - `init_valid` is ignored in this state.
  - RUN:
    - `warm_up_complete=1`, `init_ready=1`.
    - The output register is one entry deep.
    - When the output register is empty, or `out_valid & out_ready`: register the next `W` bits into `ks`, set `out_valid=1`, and advance the state `W` rounds.
    - Otherwise (`out_valid & !out_ready`): hold the state, `ks`, and `out_valid` unchanged.
- Re-key in RUN:
  - On `init_valid & init_ready`, reload the state, clear `out_valid`, and go to WARMUP.
  - If `out_valid & out_ready` in the same cycle, that word counts as delivered. No further words from the old key are issued.
- `ks` is only meaningful while `out_valid=1`. Its value while `out_valid=0` is unspecified, but it is deterministic.
- No keystream bit is skipped or duplicated across backpressure.

## Timing

- Reset (asynchronous assert, synchronous deassert expected from upstream) sets these values:
  - FSM = IDLE.
  - `init_ready=1`, `out_valid=0`, `ks=0`, `warm_up_complete=0`, `busy=0`.
  - State registers = 0.
  - Counter = 0.
- Reset mid-WARMUP or mid-RUN aborts immediately. No word is emitted after reset until a new init.
- Init handshake at edge E0. Warm-up occupies edges E1..EN, with N = `WARMUP_ROUNDS/W`. `out_valid` first rises after edge EN+1.
  - Latency from init acceptance to first word is N+1 cycles.
  - W=1: 1153 cycles. W=8: 145 cycles. W=64: 19 cycles.
- With `out_ready` held high, one word is produced per cycle: W bits/cycle sustained.
- All outputs are registered. There is no combinational path from `out_ready` or `init_valid` to any output.
- `init_ready` is combinational from the FSM state only.

## Test plan

- Reset then init with W=1, a random key/IV, and `out_ready=1`:
  - `busy` is high for exactly 1152 cycles.
  - The first `out_valid` appears 1153 cycles after acceptance.
  - 4096 bits match the single-bit generator and the C golden model.
- W=8, same key/IV:
  - First `out_valid` at 145 cycles.
  - Word k equals bits 8k..8k+7 of the W=1 stream, LSB first, for 512 words.
- W=64 with random `out_ready` (50% duty):
  - The concatenated stream equals the W=1 stream with no gaps or duplicates.
  - `ks` and `out_valid` stay stable whenever stalled.
- Re-key in RUN with `out_valid&out_ready` in the same cycle:
  - The old word counts as delivered.
  - `out_valid=0` for the next N cycles.
  - The new stream matches the golden model for the new key/IV.
- `init_valid` pulsed during WARMUP: ignored. `init_ready=0` and the stream is unchanged.
- `rst_n` asserted mid-RUN with `out_valid=1`:
  - Outputs take reset values immediately, asynchronously.
  - No `out_valid` appears until a new init plus N+1 cycles.
